// File: rtl/mem_bus_router.sv
// Slave-side CPU memory bus controller: decodes the 18-bit map into four
// regions, runs a req/ack handshake with the selected region, steers byte
// lanes and owns the frame-buffer swap register.
module mem_bus_router #(
  parameter logic [31:0] SWITCH_FB_ADDR = 32'h0002_FFFF,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic [31:0]  bus_addr,
  input  logic         bus_dispatch_read,
  input  logic         bus_dispatch_write,
  input  logic [31:0]  bus_write_data,
  input  logic [1:0]   bus_mem_width,
  output logic         bus_busy,
  output logic [31:0]  bus_read_data,
  output logic         bus_err,
  output logic         fb_select,
  output logic [3:0]   rgn_req,
  output logic         rgn_we,
  output logic [13:0]  rgn_addr,
  output logic [3:0]   rgn_be,
  output logic [31:0]  rgn_wdata,
  input  logic [3:0]   rgn_ack,
  input  logic [127:0] rgn_rdata
);

  typedef enum logic {IDLE, ACCESS} state_t;

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t        state, state_next;
  logic [1:0]    region, region_next;
  logic [1:0]    width, width_next;
  logic [1:0]    offset, offset_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [3:0]    req_next;
  logic          we_next;
  logic [13:0]   addr_next;
  logic [3:0]    be_next;
  logic [31:0]  wdata_next;
  logic [31:0]  rdata_next;
  logic          err_next;
  logic          fb_next;

  logic          dispatch;
  logic          is_write;
  logic          addr_bad;
  logic          misaligned;
  logic          rom_write;
  logic          fb_write;
  logic [3:0]    be_dec;
  logic [31:0]   sel_word;
  logic [31:0]   shifted;
  logic [31:0]   masked;
  logic          ack_hit;

  // The CPU must see busy in the same cycle as its dispatch pulse.
  assign bus_busy = (state != IDLE) | bus_dispatch_read | bus_dispatch_write;

  // Dispatch decode, lane steering and read-data extraction.
  always_comb begin
    dispatch   = bus_dispatch_read | bus_dispatch_write;
    is_write   = bus_dispatch_write;
    addr_bad   = |bus_addr[31:18];
    misaligned = ((bus_mem_width == 2'd1) && bus_addr[0])
               | ((bus_mem_width == 2'd2) && (|bus_addr[1:0]))
               | (bus_mem_width == 2'd3);
    rom_write  = is_write && (bus_addr[17:16] == 2'd0);
    fb_write   = is_write && (bus_mem_width == 2'd0) && (bus_addr == SWITCH_FB_ADDR);
    case (bus_mem_width)
      2'd0:    be_dec = 4'b0001 << bus_addr[1:0];
      2'd1:    be_dec = 4'b0011 << bus_addr[1:0];
      default: be_dec = 4'b1111;
    endcase
    sel_word = rgn_rdata[{region, 5'b00000} +: 32];
    shifted  = sel_word >> {offset, 3'b000};
    case (width)
      2'd0:    masked = {24'd0, shifted[7:0]};
      2'd1:    masked = {16'd0, shifted[15:0]};
      default: masked = shifted;
    endcase
    ack_hit = |(rgn_ack & rgn_req);
  end

  // Next-state and next-output logic for the IDLE/ACCESS handshake.
  always_comb begin
    state_next  = state;
    region_next = region;
    width_next  = width;
    offset_next = offset;
    cnt_next    = cnt;
    req_next    = rgn_req;
    we_next     = rgn_we;
    addr_next   = rgn_addr;
    be_next     = rgn_be;
    wdata_next  = rgn_wdata;
    rdata_next  = bus_read_data;
    err_next    = bus_err;
    fb_next     = fb_select;
    case (state)
      IDLE: begin
        if (dispatch) begin
          if (addr_bad || misaligned || rom_write) begin
            err_next = 1'b1;
            if (!is_write) rdata_next = ERR_DATA;
          end else if (fb_write) begin
            err_next = 1'b0;
            if (bus_write_data[0]) fb_next = ~fb_select;
          end else begin
            state_next  = ACCESS;
            region_next = bus_addr[17:16];
            width_next  = bus_mem_width;
            offset_next = bus_addr[1:0];
            cnt_next    = '0;
            req_next    = 4'b0001 << bus_addr[17:16];
            we_next     = is_write;
            addr_next   = bus_addr[15:2];
            be_next     = be_dec;
            wdata_next  = bus_write_data << {bus_addr[1:0], 3'b000};
          end
        end
      end
      ACCESS: begin
        if (ack_hit) begin
          state_next = IDLE;
          req_next   = 4'b0000;
          err_next   = 1'b0;
          if (!rgn_we) rdata_next = masked;
        end else if (cnt == CNT_LAST) begin
          state_next = IDLE;
          req_next   = 4'b0000;
          err_next   = 1'b1;
          if (!rgn_we) rdata_next = ERR_DATA;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and output registers; reset drops any access in flight.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state         <= IDLE;
      region        <= 2'd0;
      width         <= 2'd0;
      offset        <= 2'd0;
      cnt           <= '0;
      rgn_req       <= 4'b0000;
      rgn_we        <= 1'b0;
      rgn_addr      <= 14'd0;
      rgn_be        <= 4'b0000;
      rgn_wdata     <= 32'd0;
      bus_read_data <= 32'd0;
      bus_err       <= 1'b0;
      fb_select     <= 1'b0;
    end else begin
      state         <= state_next;
      region        <= region_next;
      width         <= width_next;
      offset        <= offset_next;
      cnt           <= cnt_next;
      rgn_req       <= req_next;
      rgn_we        <= we_next;
      rgn_addr      <= addr_next;
      rgn_be        <= be_next;
      rgn_wdata     <= wdata_next;
      bus_read_data <= rdata_next;
      bus_err       <= err_next;
      fb_select     <= fb_next;
    end
  end

endmodule

// File: doc/mem_bus_router.md
Name: mem_bus_router

Overview:
- Slave-side controller for the CPU memory bus. It accepts single-pulse read/write dispatches, decodes the 18-bit physical map into four regions (rom, ram, frame, io) and runs a req/ack handshake with the selected region.
- It handles width, alignment and byte-lane steering, and returns read data and busy.
- It owns the frame-buffer swap register at 0x2FFFF.
- It sits directly downstream of the cpu and upstream of the rom/ram/framebuffer/io blocks.

Parameters:
- SWITCH_FB_ADDR, 32'h2FFFF: byte address of the frame-buffer swap register.
- TIMEOUT_CYCLES, 255: maximum wait for a region ack before completing with an error.
- ERR_DATA, 32'hDEAD_BEEF: value returned on reads that end in an error.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset, asynchronous, active-low
- bus_addr  input  32  byte address
- bus_dispatch_read  input  1  one-cycle read request
- bus_dispatch_write  input  1  one-cycle write request
- bus_write_data  input  32  write data, right-justified
- bus_mem_width  input  2  access width: mem::BYTE=0, WORD=1, DWORD=2
- bus_busy  output  1  transaction in progress
- bus_read_data  output  32  read result, zero-extended and right-justified
- bus_err  output  1  last transaction failed
- fb_select  output  1  current displayed frame buffer
- rgn_req  output  4  per-region request, index = bus_addr[17:16]
- rgn_we  output  1  write strobe, shared by all regions
- rgn_addr  output  14  word address bus_addr[15:2], shared
- rgn_be  output  4  byte enables, little-endian, shared
- rgn_wdata  output  32  lane-aligned write data, shared
- rgn_ack  input  4  per-region one-cycle completion
- rgn_rdata  input  128  per-region read word; region i uses bits [32i+31:32i]

Behaviour:
- Reset (rst_in low, asynchronous):
  - Force state to IDLE.
  - Clear rgn_req, rgn_we, rgn_be, rgn_addr, rgn_wdata, bus_read_data, bus_err, fb_select and the timeout counter to 0.
  - Reset mid-access drops the request immediately; no completion is reported.
- Busy:
  - bus_busy = (state != IDLE) | bus_dispatch_read | bus_dispatch_write, computed combinationally.
  - The cpu sees busy in the same cycle its dispatch pulse is high.
- Dispatch sampling:
  - Dispatches are sampled only in IDLE; a dispatch outside IDLE is ignored.
  - If read and write are both high, the write wins and the read is dropped.
- Decode at the dispatch edge, checked in this order:
  1. bus_addr[31:18] != 0 → error.
  2. Misaligned access (WORD with addr[0] set, DWORD with addr[1:0] nonzero) or width 3 → error.
  3. Write with region 0 (rom) → error.
  4. BYTE write to SWITCH_FB_ADDR → toggle fb_select if write_data[0] is 1; no region access; bus_err cleared.
  5. Otherwise → go to ACCESS.
- Error completion:
  - Completes at the dispatch edge: bus_err=1; reads load ERR_DATA.
  - bus_busy is high for the dispatch cycle only.
- ACCESS state:
  - rgn_req[region] is registered high from the cycle after dispatch and held until the ack edge.
  - rgn_we, rgn_addr, rgn_be and rgn_wdata are stable while rgn_req is high.
  - Byte enables: BYTE → 1<<addr[1:0]; WORD → 4'b0011 << addr[1:0]; DWORD → 4'b1111.
  - rgn_wdata = bus_write_data << (8*addr[1:0]).
- Ack edge (rgn_ack[region] high while rgn_req is high):
  - Return to IDLE; clear rgn_req.
  - On reads, load bus_read_data = (rdata >> 8*addr[1:0]) masked to the access width; bus_err=0.
  - Minimum latency is 2 busy cycles (ack in the first req cycle).
  - Acks on non-selected regions are ignored.
- Timeout:
  - The counter increments on each ACCESS cycle.
  - When the count reaches TIMEOUT_CYCLES without an ack: drop rgn_req, bus_err=1, reads load ERR_DATA, return to IDLE.
- Holds:
  - bus_read_data holds until the next completed read; writes never modify it.
  - bus_err holds until the next completion.

Test Plan:
1. WORD read at 0x00006; rom acks 3 cycles after req with rdata 0xAABBCCDD → rgn_req[0]=1, rgn_addr=1, rgn_be=4'b1100; bus_read_data=0x0000AABB; bus_busy high from dispatch cycle through ack cycle, low the next cycle.
2. Back-to-back WORD write 0x20002 data 0xF7F5 with a single-cycle ack → rgn_req[2], rgn_we=1, rgn_be=4'b1100, rgn_wdata=0xF7F50000; bus_read_data unchanged.
3. BYTE write 0x2FFFF data 1, twice → fb_select 0→1→0; no rgn_req; busy one cycle each; a write with data 0 leaves fb_select unchanged.
4. Error cases, each with no rgn_req, bus_err=1, busy one cycle:
   - WORD write to 0x00010 (rom).
   - DWORD read at 0x10002 (misaligned); read returns 0xDEADBEEF.
   - Read at 0x40000 (out of map).
5. DWORD read at 0x10000 with no ack → rgn_req[1] held 255 cycles, then dropped; bus_err=1; bus_read_data=0xDEADBEEF; a subsequent successful read clears bus_err.
6. rst_in pulsed low mid-ACCESS (asynchronously, between clock edges) → rgn_req, bus_busy, fb_select, bus_read_data all 0 immediately; a late ack after release is ignored.
